ra_list_walker: RTL and testbench
=================================

# ra_list_walker

Parametrised region-array / object-list walker for the PVR render path, the next generation of the fixed five-list parser. It walks the region array from `region_base`, reads each tile's control and list-pointer words, and follows each enabled object list through OPB links. Every primitive reference is pushed through an internal FIFO to the ISP/TSP front end. It adds a ready/acknowledge memory handshake, a last-region stop, abort, a per-list enable mask and error reporting.

## Interface
- `ADDR_W`, 24: VRAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
- `NUM_LISTS`, 5: maximum list-pointer words per region entry, 1..7.
- `FIFO_DEPTH`, 4: primitive FIFO depth, power of two, ≥2.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; ignored while `busy`.
- `abort` in 1: level; stops the walk.
- `region_base` in ADDR_W: byte address of the first region entry, word aligned.
- `num_ptrs` in 3: pointer words per entry for this frame, 1..NUM_LISTS. v1 format = 4, v2 = 5.
- `list_en` in NUM_LISTS: list i is walked only if bit i = 1.
- `mem_rd` out 1: read request; held until `mem_ack`.
- `mem_addr` out ADDR_W: read byte address; stable while `mem_rd`.
- `mem_ack` in 1: `mem_din` valid this cycle; completes the request.
- `mem_din` in 32: read data.
- `region_valid` out 1: one-cycle pulse; `region_ctrl` is updated on the same cycle.
- `region_ctrl` out 32: current control word. [31] last, [30] zclear, [28] flush, [13:8] tile y, [7:2] tile x.
- `prim_valid` out 1: FIFO head valid.
- `prim_ready` in 1: consumer accepts the head when `prim_valid & prim_ready`.
- `prim_addr` out ADDR_W: {word[20:0],2'b00}, zero-extended or truncated to ADDR_W.
- `prim_word` out 32: raw OL word.
- `prim_list` out 3: list index 0..NUM_LISTS-1.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse at the end of the walk.
- `err` out 1: sticky error flag; cleared by `start`.
- `err_code` out 2: 1 = undefined OL type, 2 = aborted. Cleared by `start`.

## Operation
- Reset: all outputs 0, FSM in IDLE, FIFO empty.
- IDLE: on `start`, set `cur = region_base`, clear `err`/`err_code`, go to RD_CTRL.
- RD_CTRL: read `cur`; latch `region_ctrl`; `cur += 4`; set `k = 0`; go to RD_PTR.
- RD_PTR: read `num_ptrs` words into `ptr[k]`, `cur += 4` each. Pointers with k ≥ `num_ptrs` are forced to 0x80000000 (unused). After the last read, pulse `region_valid`, set `li = 0`, go to NEXT_LIST.
- NEXT_LIST:
  - If `li == NUM_LISTS`, go to REGION_END.
  - Else if `ptr[li][31] == 0` and `list_en[li]`: set `ola = ptr[li][ADDR_W-1:0] & ~3` and go to RD_OL.
  - Else `li += 1`. Scanning one list index costs one cycle.
- RD_OL: read `ola` into `w`; go to DECODE.
- DECODE:
  - Primitive types (`w[31] == 0`, triangle strip; `w[31:29] == 100`, triangle array; `w[31:29] == 101`, quad array):
    - If the FIFO is full, stall in DECODE.
    - Otherwise push {addr, w, li}, `ola += 4`, go to RD_OL.
  - `w[31:29] == 111` (link):
    - If `w[28] == 1` (end of list), `li += 1` and go to NEXT_LIST.
    - Else `ola = {w[23:2],2'b00}` and go to RD_OL.
  - Any other type (110): set `err = 1`, `err_code = 1`, `li += 1`, go to NEXT_LIST. The walk continues.
- REGION_END:
  - If `region_ctrl[31]`, go to DRAIN.
  - Else go to RD_CTRL using `cur`, which already points at the next entry.
- DRAIN: wait for the FIFO to be empty, then pulse `done`, drop `busy`, go to IDLE.
- Abort: `abort` sampled high in any non-IDLE state other than DRAIN:
  - An outstanding read is dropped; `mem_rd` is low the next cycle and a late `mem_ack` is ignored.
  - The FIFO is flushed.
  - `err = 1`, `err_code = 2`, go to DRAIN.
- `abort` during DRAIN has no effect. `start` while `busy` is ignored.

## Timing
- One outstanding read at a time.
- `mem_rd` rises the cycle after entering a read state. Data is captured on the `mem_ack` cycle, and the next request is issued no earlier than the following cycle.
- A `mem_ack` arriving in the same cycle that `mem_rd` rises is legal and completes the request.
- `region_valid` occurs on the cycle after the last pointer ack.
- FIFO push and pop may occur in the same cycle. A push to a full FIFO is allowed only if a pop occurs that cycle.
- `prim_*` is registered from the FIFO head. The first primitive is visible the cycle after its push.
- With zero-wait memory, each primitive costs 3 cycles (RD_OL request, ack, DECODE).
- `done` is asserted the cycle after the FIFO empties.

## Test plan
- Single last region (ctrl 0x80000000), `num_ptrs = 5`, all pointers 0x80000000 -> zero prims; one `region_valid`; `done`; `err = 0`.
- Opaque list at 0x1000: 0x00000100, 0xA0000200, 0xF0000000 -> prims at addr 0x400 (list 0) and 0x800 (list 0), then `done`.
- Link: 0x1000 holds 0xE0002000, 0x2000 holds 0x00000040 then 0xF0000000 -> one prim at addr 0x100; reads 0x1000, 0x2000, 0x2004.
- `prim_ready` held low: after FIFO_DEPTH prims the walker stalls in DECODE with no new `mem_rd`; releasing `prim_ready` delivers all prims in order with none lost.
- Two regions with `num_ptrs = 4`, second marked last -> second control read at `region_base + 20`; the list-4 pointer is treated as unused; `done` after the second region.
- OL word 0xC0000000 -> `err = 1`, `err_code = 1`, walk continues. `abort` during a pending read -> `mem_rd` low next cycle, FIFO empty, `err_code = 2`, `done` pulses.

Source files
------------

// File: rtl/ra_list_walker.sv
// Region-array / object-list walker: reads region entries and their object lists
// from VRAM and queues every primitive reference for the ISP/TSP front end.
module ra_list_walker #(
    parameter int ADDR_W     = 24,
    parameter int NUM_LISTS  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    region_base,
    input  logic [2:0]           num_ptrs,
    input  logic [NUM_LISTS-1:0] list_en,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_din,
    output logic                 region_valid,
    output logic [31:0]          region_ctrl,
    output logic                 prim_valid,
    input  logic                 prim_ready,
    output logic [ADDR_W-1:0]    prim_addr,
    output logic [31:0]          prim_word,
    output logic [2:0]           prim_list,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] UNUSED_PTR = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CTRL, S_RD_PTR, S_NEXT_LIST, S_RD_OL, S_DECODE, S_REGION_END, S_DRAIN
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
        logic [2:0]        list;
    } prim_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, ola_q, ola_d, mem_addr_q, mem_addr_d;
    logic [2:0]        k_q, k_d, li_q, li_d, np_q, np_d;
    logic [31:0]       ctrl_q, ctrl_d, w_q, w_d, region_ctrl_q, region_ctrl_d;
    logic [31:0]       ptr_q [NUM_LISTS];
    logic [31:0]       ptr_d [NUM_LISTS];
    logic              mem_rd_q, mem_rd_d, region_valid_q, region_valid_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    prim_t             fifo_q [FIFO_DEPTH];
    prim_t             fifo_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    prim_t             head, push_entry;
    logic              push, pop, flush, full, fifo_nonempty;
    logic [31:0]       sel_ptr;
    logic              sel_en, is_prim, is_link;

    assign fifo_nonempty = (cnt_q != '0);
    assign full          = (cnt_q == CW'(FIFO_DEPTH));
    assign pop           = fifo_nonempty & prim_ready;
    assign is_prim       = !w_q[31] || (w_q[31:29] == 3'b100) || (w_q[31:29] == 3'b101);
    assign is_link       = (w_q[31:29] == 3'b111);
    assign push_entry    = prim_t'{addr: ADDR_W'({w_q[20:0], 2'b00}), word: w_q, list: li_q};

    always_comb begin
        sel_ptr = UNUSED_PTR;
        sel_en  = 1'b0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            if (li_q == 3'(i)) begin
                sel_ptr = ptr_q[i];
                sel_en  = list_en[i];
            end
        end
    end

    // NOTE: every _d starts as its _q (or an explicit pulse default), so no branch can leave a latch.
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        ola_d          = ola_q;
        k_d            = k_q;
        li_d           = li_q;
        np_d           = np_q;
        ctrl_d         = ctrl_q;
        w_d            = w_q;
        ptr_d          = ptr_q;
        mem_rd_d       = mem_rd_q;
        mem_addr_d     = mem_addr_q;
        region_valid_d = 1'b0;
        region_ctrl_d  = region_ctrl_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = err_q;
        err_code_d     = err_code_q;
        push           = 1'b0;
        flush          = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                cur_d      = region_base;
                err_d      = 1'b0;
                err_code_d = 2'd0;
                busy_d     = 1'b1;
                if (num_ptrs == 3'd0)                np_d = 3'd1;
                else if (num_ptrs > 3'(NUM_LISTS))   np_d = 3'(NUM_LISTS);
                else                                 np_d = num_ptrs;
                state_d    = S_RD_CTRL;
            end
            // Each read state spends one cycle raising mem_rd, then waits for the ack.
            S_RD_CTRL: if (!mem_rd_q) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = cur_q;
            end else if (mem_ack) begin
                mem_rd_d = 1'b0;
                ctrl_d   = mem_din;
                cur_d    = cur_q + ADDR_W'(4);
                k_d      = 3'd0;
                for (int i = 0; i < NUM_LISTS; i++) ptr_d[i] = UNUSED_PTR;
                state_d  = S_RD_PTR;
            end
            S_RD_PTR: if (!mem_rd_q) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = cur_q;
            end else if (mem_ack) begin
                mem_rd_d = 1'b0;
                for (int i = 0; i < NUM_LISTS; i++) if (k_q == 3'(i)) ptr_d[i] = mem_din;
                cur_d = cur_q + ADDR_W'(4);
                k_d   = k_q + 3'd1;
                if (k_q == np_q - 3'd1) begin
                    region_valid_d = 1'b1;
                    region_ctrl_d  = ctrl_q;
                    li_d           = 3'd0;
                    state_d        = S_NEXT_LIST;
                end
            end
            S_NEXT_LIST: begin
                if (li_q == 3'(NUM_LISTS)) begin
                    state_d = S_REGION_END;
                end else if (!sel_ptr[31] && sel_en) begin
                    ola_d   = ADDR_W'({sel_ptr[31:2], 2'b00});
                    state_d = S_RD_OL;
                end else begin
                    li_d = li_q + 3'd1;
                end
            end
            S_RD_OL: if (!mem_rd_q) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = ola_q;
            end else if (mem_ack) begin
                mem_rd_d = 1'b0;
                w_d      = mem_din;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_prim) begin
                    if (!full || pop) begin
                        push    = 1'b1;
                        ola_d   = ola_q + ADDR_W'(4);
                        state_d = S_RD_OL;
                    end
                end else if (is_link) begin
                    if (w_q[28]) begin
                        li_d    = li_q + 3'd1;
                        state_d = S_NEXT_LIST;
                    end else begin
                        ola_d   = ADDR_W'({w_q[23:2], 2'b00});
                        state_d = S_RD_OL;
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    li_d       = li_q + 3'd1;
                    state_d    = S_NEXT_LIST;
                end
            end
            S_REGION_END: state_d = ctrl_q[31] ? S_DRAIN : S_RD_CTRL;
            S_DRAIN: if (!fifo_nonempty) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops any pending read; a late ack is ignored because mem_rd is already low.
        if (abort && state_q != S_IDLE && state_q != S_DRAIN) begin
            mem_rd_d       = 1'b0;
            region_valid_d = 1'b0;
            push           = 1'b0;
            flush          = 1'b1;
            err_d          = 1'b1;
            err_code_d     = 2'd2;
            state_d        = S_DRAIN;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                fifo_d[wr_q] = push_entry;
                wr_d         = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cur_q          <= '0;
            ola_q          <= '0;
            k_q            <= '0;
            li_q           <= '0;
            np_q           <= '0;
            ctrl_q         <= '0;
            w_q            <= '0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= '0;
            region_valid_q <= 1'b0;
            region_ctrl_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            for (int i = 0; i < NUM_LISTS; i++) ptr_q[i] <= '0;
            // NOTE: the FIFO storage is only a few entries, so it is reset to keep prim_* at zero.
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            ola_q          <= ola_d;
            k_q            <= k_d;
            li_q           <= li_d;
            np_q           <= np_d;
            ctrl_q         <= ctrl_d;
            w_q            <= w_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
            region_valid_q <= region_valid_d;
            region_ctrl_q  <= region_ctrl_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            fifo_q         <= fifo_d;
        end
    end

    assign head         = fifo_q[rd_q];
    assign prim_valid   = fifo_nonempty;
    assign prim_addr    = head.addr;
    assign prim_word    = head.word;
    assign prim_list    = head.list;
    assign mem_rd       = mem_rd_q;
    assign mem_addr     = mem_addr_q;
    assign region_valid = region_valid_q;
    assign region_ctrl  = region_ctrl_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule

// File: tb/tb_ra_list_walker.sv
// Randomised bench for ra_list_walker: a VRAM model with random ack latency, a
// sequential reference walker filling scoreboards, and monitors that pop them.
module tb_ra_list_walker;
    localparam int ADDR_W     = 24;
    localparam int NUM_LISTS  = 5;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] word;
        logic [2:0]  list;
    } prim_t;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [ADDR_W-1:0]    region_base = '0;
    logic [2:0]           num_ptrs = 3'd5;
    logic [NUM_LISTS-1:0] list_en = '1;
    logic                 mem_rd;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_ack = 1'b0;
    logic [31:0]          mem_din = '0;
    logic                 region_valid;
    logic [31:0]          region_ctrl;
    logic                 prim_valid;
    logic                 prim_ready = 1'b0;
    logic [ADDR_W-1:0]    prim_addr;
    logic [31:0]          prim_word;
    logic [2:0]           prim_list;
    logic                 busy, done, err;
    logic [1:0]           err_code;

    ra_list_walker #(.ADDR_W(ADDR_W), .NUM_LISTS(NUM_LISTS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .region_base(region_base), .num_ptrs(num_ptrs), .list_en(list_en),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_din(mem_din),
        .region_valid(region_valid), .region_ctrl(region_ctrl),
        .prim_valid(prim_valid), .prim_ready(prim_ready), .prim_addr(prim_addr),
        .prim_word(prim_word), .prim_list(prim_list),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] vram [int unsigned];
    prim_t       exp_prims [$];
    logic [31:0] exp_regions [$];
    logic [23:0] exp_reads [$];
    bit          sb_en = 1'b1;
    bit          check_reads = 1'b1;
    bit          force_lat = 1'b0;
    int          rdy_mode = 0;
    int          n_reqs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 1 event, expected 0", name);
    endtask

    function automatic logic [31:0] rd(input logic [23:0] a);
        if (vram.exists(32'(a))) return vram[32'(a)];
        return 32'hF000_0000;
    endfunction

    task automatic wr(input logic [23:0] a, input logic [31:0] w);
        vram[32'(a)] = w;
    endtask

    // Reference walker: follows the region/list format directly as a sequential program.
    task automatic model_walk(input logic [23:0] base, input int np, input logic [4:0] en,
                              output logic e, output logic [1:0] c);
        logic [23:0] cur, ola;
        logic [31:0] ctrl, w;
        logic [31:0] ptr [5];
        e = 1'b0;
        c = 2'd0;
        cur = base;
        forever begin
            exp_reads.push_back(cur);
            ctrl = rd(cur);
            cur += 24'd4;
            for (int k = 0; k < 5; k++) begin
                if (k < np) begin
                    exp_reads.push_back(cur);
                    ptr[k] = rd(cur);
                    cur += 24'd4;
                end else begin
                    ptr[k] = 32'h8000_0000;
                end
            end
            exp_regions.push_back(ctrl);
            for (int li = 0; li < 5; li++) begin
                if (ptr[li][31] || !en[li]) continue;
                ola = ptr[li][23:0] & 24'hFF_FFFC;
                for (int steps = 0; steps < 1000; steps++) begin
                    exp_reads.push_back(ola);
                    w = rd(ola);
                    if (!w[31] || w[31:29] == 3'b100 || w[31:29] == 3'b101) begin
                        exp_prims.push_back(prim_t'{24'((w & 32'h001F_FFFF) * 4), w, 3'(li)});
                        ola += 24'd4;
                    end else if (w[31:29] == 3'b111) begin
                        if (w[28]) break;
                        ola = w[23:0] & 24'hFF_FFFC;
                    end else begin
                        e = 1'b1;
                        c = 2'd1;
                        break;
                    end
                end
            end
            if (ctrl[31]) break;
        end
    endtask

    // VRAM responder: random 0..2 cycle latency, ack may coincide with the first mem_rd cycle.
    initial begin
        bit          in_req;
        int          lat;
        logic [23:0] req_addr;
        in_req = 1'b0;
        lat = 0;
        req_addr = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (reset_n && mem_rd) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    req_addr = mem_addr;
                    lat = force_lat ? 3 : int'($urandom_range(0, 2));
                    n_reqs++;
                end else begin
                    check("mem_addr_stable", mem_addr, req_addr);
                end
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    mem_din = rd(mem_addr);
                    in_req = 1'b0;
                    if (check_reads) begin
                        if (exp_reads.size() == 0) fail_now("read_unexpected");
                        else check("read_addr", mem_addr, exp_reads.pop_front());
                    end
                end else begin
                    lat--;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Consumer and output monitor.
    initial forever begin
        @(negedge clock);
        case (rdy_mode)
            0:       prim_ready = ($urandom_range(0, 3) != 0);
            1:       prim_ready = 1'b0;
            default: prim_ready = 1'b1;
        endcase
        if (reset_n && sb_en && prim_valid && prim_ready) begin
            if (exp_prims.size() == 0) fail_now("prim_unexpected");
            else check("prim", {prim_addr, prim_word, prim_list}, exp_prims.pop_front());
        end
        if (reset_n && sb_en && region_valid) begin
            if (exp_regions.size() == 0) fail_now("region_unexpected");
            else check("region_ctrl", region_ctrl, exp_regions.pop_front());
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic start_frame(input string name, input logic [23:0] base, input logic [2:0] np,
                               input logic [4:0] en, output logic e, output logic [1:0] c);
        model_walk(base, int'(np), en, e, c);
        region_base = base;
        num_ptrs = np;
        list_en = en;
        pulse_start();
        check({name, "_busy"}, busy, 1'b1);
    endtask

    task automatic wait_for_done(input string name, output bit seen);
        seen = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({name, "_done"}, seen, 1'b1);
    endtask

    task automatic finish_frame(input string name, input logic e, input logic [1:0] c);
        bit seen;
        wait_for_done(name, seen);
        if (seen) begin
            check({name, "_busy_low"}, busy, 1'b0);
            check({name, "_err"}, err, e);
            check({name, "_err_code"}, err_code, c);
        end
        check({name, "_prims_left"}, exp_prims.size(), 0);
        check({name, "_regions_left"}, exp_regions.size(), 0);
        check({name, "_reads_left"}, exp_reads.size(), 0);
        exp_prims.delete();
        exp_regions.delete();
        exp_reads.delete();
        @(negedge clock);
    endtask

    task automatic run_walk(input string name, input logic [23:0] base, input logic [2:0] np,
                            input logic [4:0] en);
        logic e;
        logic [1:0] c;
        start_frame(name, base, np, en, e, c);
        finish_frame(name, e, c);
    endtask

    function automatic logic [31:0] rand_prim();
        case ($urandom_range(0, 2))
            0:       return {1'b0, 31'($urandom)};
            1:       return {3'b100, 29'($urandom)};
            default: return {3'b101, 29'($urandom)};
        endcase
    endfunction

    task automatic gen_list(input logic [23:0] la);
        logic [23:0] p;
        int n;
        p = la;
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin wr(p, rand_prim()); p += 24'd4; end
        case ($urandom_range(0, 7))
            0: wr(p, 32'hC000_0000 | ($urandom & 32'h1FFF_FFFF));
            1, 2: begin
                wr(p, 32'hE000_0000 | 32'(la + 24'h80) | ($urandom & 32'h0F00_0003));
                p = la + 24'h80;
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin wr(p, rand_prim()); p += 24'd4; end
                wr(p, 32'hF000_0000);
            end
            default: wr(p, 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF));
        endcase
    endtask

    task automatic gen_frame(output logic [23:0] base, output logic [2:0] np, output logic [4:0] en);
        int nr;
        logic [23:0] a, la;
        logic [31:0] w;
        vram.delete();
        base = 24'($urandom_range(1, 255) * 16);
        np = 3'($urandom_range(1, 5));
        en = 5'($urandom);
        nr = $urandom_range(1, 3);
        a = base;
        for (int r = 0; r < nr; r++) begin
            w = $urandom & 32'h5000_3FFC;
            if (r == nr - 1) w[31] = 1'b1;
            wr(a, w);
            a += 24'd4;
            for (int k = 0; k < int'(np); k++) begin
                la = 24'h01_0000 + 24'(r * 'h1000 + k * 'h100);
                if ($urandom_range(0, 4) == 0) begin
                    wr(a, 32'h8000_0000 | $urandom);
                end else begin
                    wr(a, {1'b0, 7'($urandom), la} | 32'($urandom_range(0, 3)));
                    gen_list(la);
                end
                a += 24'd4;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] base;
        logic [2:0]  np;
        logic [4:0]  en;
        logic        e;
        logic [1:0]  c;
        bit          seen, hit;
        int          r0;

        repeat (3) @(negedge clock);
        check("reset_ctrl_outs", {mem_rd, busy, done, err, err_code, prim_valid, region_valid}, '0);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset_data_outs", {mem_addr, region_ctrl, prim_addr, prim_word, prim_list}, '0);

        // Single last region, every pointer unused.
        vram.delete();
        wr(24'h000100, 32'h8000_0000);
        for (int k = 1; k <= 5; k++) wr(24'h000100 + 24'(4 * k), 32'h8000_0000);
        run_walk("empty", 24'h000100, 3'd5, 5'h1F);

        // Opaque list of two primitives.
        vram.delete();
        wr(24'h000100, 32'h8000_0000);
        wr(24'h000104, 32'h0000_1000);
        for (int k = 2; k <= 5; k++) wr(24'h000100 + 24'(4 * k), 32'h8000_0000);
        wr(24'h001000, 32'h0000_0100);
        wr(24'h001004, 32'hA000_0200);
        wr(24'h001008, 32'hF000_0000);
        run_walk("opaque", 24'h000100, 3'd5, 5'h1F);

        // Link followed to a second block.
        wr(24'h001000, 32'hE000_2000);
        wr(24'h002000, 32'h0000_0040);
        wr(24'h002004, 32'hF000_0000);
        run_walk("link", 24'h000100, 3'd5, 5'h1F);

        // Two regions, four pointers each; second control word sits at base + 20.
        vram.delete();
        wr(24'h000300, 32'h0000_0104);
        wr(24'h000304, 32'h8000_0000);
        wr(24'h000308, 32'h0000_6000);
        wr(24'h00030C, 32'h8000_0000);
        wr(24'h000310, 32'h8000_0000);
        wr(24'h000314, 32'h8000_0208);
        for (int k = 1; k <= 4; k++) wr(24'h000314 + 24'(4 * k), 32'h8000_0000);
        wr(24'h006000, 32'h8000_0010);
        wr(24'h006004, 32'hF000_0000);
        run_walk("two_regions", 24'h000300, 3'd4, 5'h1F);

        // Undefined OL type in list 0; list 1 is still walked.
        vram.delete();
        wr(24'h000100, 32'h8000_0000);
        wr(24'h000104, 32'h0000_3000);
        wr(24'h000108, 32'h0000_3100);
        for (int k = 3; k <= 5; k++) wr(24'h000100 + 24'(4 * k), 32'h8000_0000);
        wr(24'h003000, 32'h0000_0010);
        wr(24'h003004, 32'hC000_0000);
        wr(24'h003100, 32'h0000_0020);
        wr(24'h003104, 32'hF000_0000);
        run_walk("bad_type", 24'h000100, 3'd5, 5'h1F);

        // Back-pressure: FIFO fills, walker stalls in DECODE, start is ignored while busy.
        vram.delete();
        wr(24'h000100, 32'h8000_0000);
        wr(24'h000104, 32'h0000_4000);
        for (int k = 2; k <= 5; k++) wr(24'h000100 + 24'(4 * k), 32'h8000_0000);
        for (int i = 0; i < 6; i++) wr(24'h004000 + 24'(4 * i), 32'h0000_0100 + 32'(i));
        wr(24'h004018, 32'hF000_0000);
        rdy_mode = 1;
        r0 = n_reqs;
        start_frame("stall", 24'h000100, 3'd5, 5'h1F, e, c);
        repeat (150) @(negedge clock);
        check("stall_reads", n_reqs - r0, 6 + FIFO_DEPTH + 1);
        check("stall_prim_valid", prim_valid, 1'b1);
        pulse_start();
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (mem_rd) seen = 1'b1;
        end
        check("stall_no_mem_rd", seen, 1'b0);
        check("stall_reads_after", n_reqs - r0, 6 + FIFO_DEPTH + 1);
        rdy_mode = 2;
        finish_frame("stall", e, c);
        rdy_mode = 0;

        // Abort while an OL read is pending with primitives queued.
        vram.delete();
        wr(24'h000200, 32'h8000_0000);
        wr(24'h000204, 32'h0000_5000);
        for (int k = 2; k <= 5; k++) wr(24'h000200 + 24'(4 * k), 32'h8000_0000);
        for (int i = 0; i < 8; i++) wr(24'h005000 + 24'(4 * i), 32'h0000_0200 + 32'(i));
        wr(24'h005020, 32'hF000_0000);
        sb_en = 1'b0;
        check_reads = 1'b0;
        force_lat = 1'b1;
        rdy_mode = 1;
        region_base = 24'h000200;
        num_ptrs = 3'd5;
        list_en = 5'h1F;
        r0 = n_reqs;
        pulse_start();
        hit = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            if (mem_rd && (n_reqs - r0) >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached", hit, 1'b1);
        if (hit) begin
            check("abort_fifo_before", prim_valid, 1'b1);
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            check("abort_mem_rd", mem_rd, 1'b0);
            check("abort_fifo_flushed", prim_valid, 1'b0);
            check("abort_err", {err, err_code}, {1'b1, 2'd2});
            wait_for_done("abort", seen);
            if (seen) check("abort_busy_low", busy, 1'b0);
        end
        @(negedge clock);
        sb_en = 1'b1;
        check_reads = 1'b1;
        force_lat = 1'b0;
        rdy_mode = 0;
        exp_prims.delete();
        exp_regions.delete();
        exp_reads.delete();

        // Randomised frames.
        for (int t = 0; t < 12; t++) begin
            gen_frame(base, np, en);
            run_walk($sformatf("rand%0d", t), base, np, en);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
